// File: rtl/draw_sprite_pkg.sv
// Shared constants for the VGA overlay pipeline.
// HOR_PIXELS/VER_PIXELS describe the visible raster; the SPR_* values are the
// default sprite geometry and the colour key that the sprite ROM uses for see-through pixels.
package draw_sprite_pkg;

  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned VER_PIXELS = 600;

  localparam int unsigned SPR_W_DEF       = 64;
  localparam int unsigned SPR_H_DEF       = 64;
  localparam logic [11:0] SPR_TRANSPARENT = 12'hF0F;

  // Packed width of the timing fields {vcount, vsync, vblnk, hcount, hsync, hblnk}.
  localparam int unsigned VGA_TIM_W = 26;

endpackage

// File: rtl/draw_sprite_if.sv
// VGA pixel stream bundle passed between pipeline stages.
// Modports:
//   vga_out - driver side (stage producing the stream)
//   vga_in  - receiver side (stage consuming the stream)
interface draw_sprite_if;

  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport vga_out (
    output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
  );

  modport vga_in (
    input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
  );

endinterface

// File: rtl/draw_sprite_delay.sv
// Reset-clearable shift register delaying a bus by CLK_DEL clocks.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears every stage
//   din  - input word
//   dout - din delayed by CLK_DEL clocks
module draw_sprite_delay #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [CLK_DEL];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CLK_DEL); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(CLK_DEL); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[CLK_DEL-1];

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: paints one SPR_W x SPR_H sprite from an external synchronous ROM
// onto the incoming VGA stream at a position latched once per frame.
// Ports:
//   clk, rst   - pixel clock, synchronous active-high reset
//   vga_in     - background-painted stream
//   vga_out    - stream with sprite overlaid, 2 clocks behind vga_in
//   xpos, ypos - requested sprite top-left corner
//   mirror     - requested horizontal flip
//   pos_valid  - one-cycle strobe capturing xpos/ypos/mirror
//   pixel_addr - ROM address, combinational from the current input pixel
//   rgb_pixel  - ROM data, valid one clock after pixel_addr
module draw_sprite
  import draw_sprite_pkg::*;
#(
  parameter int unsigned SPR_W       = SPR_W_DEF,
  parameter int unsigned SPR_H       = SPR_H_DEF,
  parameter logic [11:0] TRANSPARENT = SPR_TRANSPARENT,
  parameter int unsigned ADDR_W      = $clog2(SPR_W * SPR_H)
) (
  input  logic              clk,
  input  logic              rst,
  draw_sprite_if.vga_in     vga_in,
  draw_sprite_if.vga_out    vga_out,
  input  logic [10:0]       xpos,
  input  logic [10:0]       ypos,
  input  logic              mirror,
  input  logic              pos_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [11:0]       rgb_pixel
);

  localparam int unsigned COL_W = $clog2(SPR_W);
  localparam int unsigned ROW_W = ADDR_W - COL_W;

  logic [10:0] x_pend, y_pend, x_act, y_act;
  logic        mir_pend, mir_act, pend, vblnk_prev;
  logic        frame_start;

  // Position only moves on the rising edge of vblnk so a frame is never torn.
  assign frame_start = vga_in.vblnk & ~vblnk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_pend     <= '0;
      y_pend     <= '0;
      mir_pend   <= 1'b0;
      pend       <= 1'b0;
      x_act      <= '0;
      y_act      <= '0;
      mir_act    <= 1'b0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vga_in.vblnk;
      if (frame_start) begin
        // A strobe landing on the boundary itself is newer than anything pending.
        if (pos_valid) begin
          x_act   <= xpos;
          y_act   <= ypos;
          mir_act <= mirror;
        end else if (pend) begin
          x_act   <= x_pend;
          y_act   <= y_pend;
          mir_act <= mir_pend;
        end
        pend <= 1'b0;
      end else if (pos_valid) begin
        x_pend   <= xpos;
        y_pend   <= ypos;
        mir_pend <= mirror;
        pend     <= 1'b1;
      end
    end
  end

  // Hit test in 12 bits so x_act + SPR_W cannot wrap back to column 0.
  logic [11:0] h_ext, v_ext, x_lo, y_lo, x_hi, y_hi;
  logic        in_spr;
  logic [COL_W-1:0] col_raw, col;
  logic [ROW_W-1:0] row;

  always_comb begin
    h_ext  = {1'b0, vga_in.hcount};
    v_ext  = {1'b0, vga_in.vcount};
    x_lo   = {1'b0, x_act};
    y_lo   = {1'b0, y_act};
    x_hi   = x_lo + 12'(SPR_W);
    y_hi   = y_lo + 12'(SPR_H);
    in_spr = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi) &&
             !vga_in.hblnk && !vga_in.vblnk;

    col_raw    = COL_W'(vga_in.hcount - x_act);
    col        = mir_act ? (COL_W'(SPR_W - 1) - col_raw) : col_raw;
    row        = ROW_W'(vga_in.vcount - y_act);
    pixel_addr = in_spr ? {row, col} : '0;
  end

  // Timing fields need two stages; rgb and the hit flag need one, so they line up with
  // the ROM word arriving in the following cycle.
  logic [VGA_TIM_W-1:0] tim_in, tim_out;
  logic [12:0]          s1_in, s1_out;
  logic                 in_spr_d;
  logic [11:0]          rgb_d, rgb_mux, rgb_q;

  assign tim_in = {vga_in.vcount, vga_in.vsync, vga_in.vblnk,
                   vga_in.hcount, vga_in.hsync, vga_in.hblnk};
  assign s1_in  = {in_spr, vga_in.rgb};

  draw_sprite_delay #(
    .WIDTH   (VGA_TIM_W),
    .CLK_DEL (2)
  ) u_tim_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (tim_in),
    .dout (tim_out)
  );

  draw_sprite_delay #(
    .WIDTH   (13),
    .CLK_DEL (1)
  ) u_rgb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (s1_in),
    .dout (s1_out)
  );

  assign in_spr_d = s1_out[12];
  assign rgb_d    = s1_out[11:0];
  assign rgb_mux  = (in_spr_d && (rgb_pixel != TRANSPARENT)) ? rgb_pixel : rgb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_mux;
    end
  end

  assign vga_out.vcount = tim_out[25:15];
  assign vga_out.vsync  = tim_out[14];
  assign vga_out.vblnk  = tim_out[13];
  assign vga_out.hcount = tim_out[12:2];
  assign vga_out.hsync  = tim_out[1];
  assign vga_out.hblnk  = tim_out[0];
  assign vga_out.rgb    = rgb_q;

endmodule

// File: tb/tb_draw_sprite.sv
// Self-checking bench for draw_sprite: directed scenarios plus randomized frames, checked
// against a pixel-level reference model and a bench-side synchronous ROM.
module tb_draw_sprite;
  import draw_sprite_pkg::HOR_PIXELS;
  import draw_sprite_pkg::VER_PIXELS;

  localparam int          SW  = 64;
  localparam int          SH  = 64;
  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] xpos = '0, ypos = '0;
  logic        mirror = 1'b0, pos_valid = 1'b0;
  logic [11:0] pixel_addr;
  logic [11:0] rgb_pixel = '0;

  draw_sprite_if vin ();
  draw_sprite_if vout ();

  draw_sprite dut (
    .clk        (clk),
    .rst        (rst),
    .vga_in     (vin),
    .vga_out    (vout),
    .xpos       (xpos),
    .ypos       (ypos),
    .mirror     (mirror),
    .pos_valid  (pos_valid),
    .pixel_addr (pixel_addr),
    .rgb_pixel  (rgb_pixel)
  );

  always #5 clk = ~clk;

  // Synchronous sprite ROM
  logic [11:0] rom [4096];
  always @(posedge clk) rgb_pixel <= rom[pixel_addr];

  int checks = 0, passes = 0, fails = 0;
  bit armed = 0;

  // Reference model state
  int   m_x, m_y, p_x, p_y;
  bit   m_mir, p_mir, m_pend, m_prev_vb;
  logic [37:0] exp_out;
  logic [37:0] q_tim_rgb;   // pixel accepted one edge ago (timing + background rgb)
  bit   q_hit;
  int   q_addr;

  // Strobe request applied on the next pixel
  bit s_pv; int s_x, s_y; bit s_m;
  logic [11:0] last_addr;

  task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic void ref_addr(input int h, input int v, output bit hit, output int a);
    int c;
    hit = h >= m_x && h < m_x + SW && v >= m_y && v < m_y + SH &&
          h < int'(HOR_PIXELS) && v < int'(VER_PIXELS);
    c = h - m_x;
    if (m_mir) c = SW - 1 - c;
    a = hit ? (v - m_y) * SW + c : 0;
  endfunction

  task automatic strobe(input int x, input int y, input bit m);
    s_pv = 1; s_x = x; s_y = y; s_m = m;
  endtask

  // One pixel: check previous output, drive, check address, advance model at the edge.
  task automatic pix(input int h, input int v, input logic [11:0] bg);
    bit hit; int a; bit hb, vb, hs, vs; logic [11:0] r;
    @(negedge clk);
    if (armed) check("vga_out", {vout.vcount, vout.vsync, vout.vblnk, vout.hcount,
                                 vout.hsync, vout.hblnk, vout.rgb}, exp_out);
    hb = h >= int'(HOR_PIXELS);
    vb = v >= int'(VER_PIXELS);
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    vin.hcount = 11'(h); vin.vcount = 11'(v);
    vin.hblnk = hb; vin.vblnk = vb; vin.hsync = hs; vin.vsync = vs; vin.rgb = bg;
    pos_valid = s_pv; xpos = 11'(s_x); ypos = 11'(s_y); mirror = s_m;
    #1;
    ref_addr(h, v, hit, a);
    if (armed) check("pixel_addr", 38'(pixel_addr), 38'(a));
    last_addr = pixel_addr;
    @(posedge clk);
    if (rst) begin
      m_x = 0; m_y = 0; m_mir = 0; m_pend = 0; p_x = 0; p_y = 0; p_mir = 0;
      m_prev_vb = 0; exp_out = '0; q_tim_rgb = '0; q_hit = 0; q_addr = 0;
    end else begin
      r = q_tim_rgb[11:0];
      if (q_hit && rom[q_addr] != KEY) r = rom[q_addr];
      exp_out   = {q_tim_rgb[37:12], r};
      q_tim_rgb = {11'(v), vs, vb, 11'(h), hs, hb, bg};
      q_hit = hit; q_addr = a;
      if (vb && !m_prev_vb) begin
        if (s_pv) begin m_x = s_x; m_y = s_y; m_mir = s_m; end
        else if (m_pend) begin m_x = p_x; m_y = p_y; m_mir = p_mir; end
        m_pend = 0;
      end else if (s_pv) begin
        p_x = s_x; p_y = s_y; p_mir = s_m; m_pend = 1;
      end
      m_prev_vb = vb;
    end
    s_pv = 0;
    armed = 1;
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) pix(h, v, 12'($urandom));
  endtask

  task automatic frame_edge();
    for (int i = 0; i < 3; i++) pix(i, int'(VER_PIXELS), 12'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
    rom[0]    = 12'h123;
    rom[650]  = KEY;       // (110,210) with sprite at (100,200)
    rom[651]  = 12'h0AB;
    rom[4095] = 12'h7E7;

    // Reset held three cycles mid-line
    rst = 1;
    pix(500, 100, 12'hABC); pix(501, 100, 12'hABC); pix(502, 100, 12'hABC);
    #1;
    check("reset_out", {vout.vcount, vout.vsync, vout.vblnk, vout.hcount,
                        vout.hsync, vout.hblnk, vout.rgb}, 38'h0);
    check("reset_addr", 38'(pixel_addr), 38'h0);
    rst = 0;
    line(100, 503, 520);

    // Placement: current frame unchanged
    strobe(100, 200, 0);
    line(200, 90, 99);
    pix(100, 200, 12'h3C3); pix(101, 200, 12'h3C3);
    #1 check("old_frame_bg", 38'(vout.rgb), 38'h3C3);
    line(200, 102, 170);
    frame_edge();
    pix(99, 200, 12'h111);
    pix(100, 200, 12'h111);
    check("addr_origin", 38'(last_addr), 38'd0);
    pix(101, 200, 12'h111);
    #1 check("rom_rgb_origin", 38'(vout.rgb), 38'h123);
    line(200, 102, 170);
    pix(163, 263, 12'h246);
    check("addr_corner", 38'(last_addr), 38'd4095);
    pix(164, 263, 12'h246);
    check("addr_outside", 38'(last_addr), 38'd0);
    pix(165, 263, 12'h246);
    #1 check("outside_bg", 38'(vout.rgb), 38'h246);

    // Transparency
    pix(110, 210, 12'h555); pix(111, 210, 12'h555);
    #1 check("key_passes_bg", 38'(vout.rgb), 38'h555);
    pix(112, 210, 12'h555);
    #1 check("neighbour_rom", 38'(vout.rgb), 38'h0AB);
    line(210, 113, 120);

    // Mirror
    strobe(100, 200, 1);
    pix(0, 300, 12'h000);
    frame_edge();
    pix(100, 200, 12'h222);
    check("mirror_left", 38'(last_addr), 38'd63);
    pix(163, 200, 12'h222);
    check("mirror_right", 38'(last_addr), 38'd0);
    line(230, 95, 170);

    // Boundary race: last strobe on the vblnk-rise cycle wins, pend is cleared
    strobe(10, 200, 0); pix(0, 300, 12'h000);
    strobe(20, 200, 0); pix(1, 300, 12'h000);
    strobe(30, 200, 0);
    frame_edge();
    pix(93, 200, 12'h333);
    check("race_x30", 38'(last_addr), 38'd63);
    line(201, 5, 100);
    frame_edge();
    pix(93, 200, 12'h333);
    check("race_no_stale", 38'(last_addr), 38'd63);

    // Clipping at the right edge: nothing painted, no wrap
    strobe(1000, 590, 0); pix(0, 300, 12'h000);
    frame_edge();
    line(595, 990, 1060);
    pix(0, 590, 12'h444);
    check("no_wrap", 38'(last_addr), 38'd0);
    line(590, 1, 70);
    // Clipping at the bottom: only 10 rows
    strobe(100, 590, 0); pix(0, 300, 12'h000);
    frame_edge();
    pix(100, 599, 12'h444);
    check("bottom_row", 38'(last_addr), 38'd576);
    line(598, 95, 170);
    pix(100, 600, 12'h444);
    check("below_clip", 38'(last_addr), 38'd0);
    line(610, 95, 170);

    // Randomized frames
    for (int f = 0; f < 15; f++) begin
      int x, y;
      x = $urandom_range(0, 1100);
      y = $urandom_range(0, 650);
      strobe(x, y, 1'($urandom_range(0, 1)));
      line(y - 3 < 0 ? 0 : y - 3, 0, 5);
      if ($urandom_range(0, 1) == 1) begin
        strobe($urandom_range(0, 1100), $urandom_range(0, 650), 1'($urandom_range(0, 1)));
        pix(7, 0, 12'h000);
      end
      if ($urandom_range(0, 2) == 0) strobe($urandom_range(0, 900), $urandom_range(0, 600), 1);
      frame_edge();
      for (int l = 0; l < 5; l++)
        line(y + $urandom_range(0, 70) - 3 < 0 ? 0 : y + $urandom_range(0, 70) - 3,
             x - 5 < 0 ? 0 : x - 5, x + 70);
    end

    pix(0, 0, 12'h000);
    pix(1, 0, 12'h000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
